// File: rtl/entropy_collector.sv
// rtl/entropy_collector.sv - ring-oscillator entropy collector with repetition health test; option ENTROPY_COLLECTOR_VON_NEUMANN_EN
module entropy_collector #(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       raw_bit,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       health_fail
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FAIL    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       sync1;
    logic       sync2;
    logic [7:0] div_cnt;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [7:0] rep_cnt;
    logic       prev_sample;

    logic       active;
    logic       strobe;
    logic [7:0] rep_next;
    logic       trip;
    logic       take;
    logic       bit_val;
    logic       complete;
    logic       load;
    logic       clear_collect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            sync2 <= sync1;
        end
    end

    always_comb begin
        active        = (state == COLLECT) && ena;
        clear_collect = !ena || (state == FAIL);
        strobe        = active && (div_cnt == 8'(SAMPLE_DIV - 1));
        rep_next      = ((rep_cnt == 8'd0) || (sync2 != prev_sample)) ? 8'd1 : rep_cnt + 8'd1;
        trip          = strobe && (rep_next == 8'(REP_LIMIT));
    end

`ifdef ENTROPY_COLLECTOR_VON_NEUMANN_EN
    logic pair_have;
    logic pair_first;

    // Second sample of a pair decides; the first sample is the emitted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
        end else if (clear_collect) begin
            pair_have  <= 1'b0;
            pair_first <= 1'b0;
        end else if (strobe) begin
            pair_have <= !pair_have;
            if (!pair_have) begin
                pair_first <= sync2;
            end
        end
    end

    always_comb begin
        take    = strobe && pair_have && (pair_first != sync2);
        bit_val = pair_first;
    end
`else
    always_comb begin
        take    = strobe;
        bit_val = sync2;
    end
`endif

    always_comb begin
        complete = take && (bit_cnt == 3'd7) && !trip;
        load     = complete && (!byte_valid || byte_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= 8'd0;
            shreg       <= 8'd0;
            bit_cnt     <= 3'd0;
            rep_cnt     <= 8'd0;
            prev_sample <= 1'b0;
        end else if (clear_collect) begin
            div_cnt     <= 8'd0;
            shreg       <= 8'd0;
            bit_cnt     <= 3'd0;
            rep_cnt     <= 8'd0;
            prev_sample <= 1'b0;
        end else if (active) begin
            div_cnt <= strobe ? 8'd0 : div_cnt + 8'd1;
            if (strobe) begin
                rep_cnt     <= rep_next;
                prev_sample <= sync2;
            end
            if (take) begin
                shreg   <= {shreg[6:0], bit_val};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // A completed byte is dropped when the previous one is still unconsumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_out    <= 8'd0;
            byte_valid  <= 1'b0;
            health_fail <= 1'b0;
        end else if ((state == FAIL) || trip) begin
            byte_valid  <= 1'b0;
            health_fail <= 1'b1;
        end else if (load) begin
            byte_out   <= {shreg[6:0], bit_val};
            byte_valid <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (trip || (state == FAIL)) begin
            state_next = FAIL;
        end else if (ena) begin
            state_next = COLLECT;
        end else begin
            state_next = IDLE;
        end
    end

endmodule

// File: tb/tb_entropy_collector.sv
// tb/tb_entropy_collector.sv - scoreboard bench for entropy_collector; honours ENTROPY_COLLECTOR_VON_NEUMANN_EN
module tb_entropy_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       raw_bit = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       health_fail;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] expq[$];
    bit         m_bits[$];
    bit         m_have = 1'b0;
    bit         m_first = 1'b0;
    bit         slot_full = 1'b0;

    always #5 clk = ~clk;

    entropy_collector #(.SAMPLE_DIV(4), .REP_LIMIT(31)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .raw_bit(raw_bit),
        .byte_out(byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .health_fail(health_fail)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_bits.delete();
        m_have = 1'b0;
    endfunction

    // Reference: debias (optional), gather 8 bits MSB-first, one-deep slot when consumer stalls.
    task automatic model_sample(input bit s);
        logic [7:0] v;
`ifdef ENTROPY_COLLECTOR_VON_NEUMANN_EN
        if (!m_have) begin
            m_first = s;
            m_have  = 1'b1;
        end else begin
            m_have = 1'b0;
            if (m_first != s) m_bits.push_back(m_first);
        end
`else
        m_bits.push_back(s);
`endif
        if (m_bits.size() == 8) begin
            v = 8'd0;
            for (int i = 0; i < 8; i++) v = v * 2 + 8'(m_bits[i]);
            m_bits.delete();
            if (byte_ready) begin
                expq.push_back(v);
            end else if (!slot_full) begin
                slot_full = 1'b1;
                expq.push_back(v);
            end
        end
    endtask

    task automatic send_sample(input bit s);
        raw_bit = s;
        model_sample(s);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
`ifdef ENTROPY_COLLECTOR_VON_NEUMANN_EN
        send_sample(b);
        send_sample(!b);
`else
        send_sample(b);
`endif
    endtask

    task automatic start_session();
        ena = 1'b1;
    endtask

    task automatic stop_session();
        @(posedge clk);
        #1;
        ena = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        ena = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_health_fail", health_fail, 1'b0);
        expq.delete();
        model_reset();
        slot_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && byte_valid) begin
            if (byte_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", byte_out);
                end else begin
                    check("byte_out", byte_out, expq.pop_front());
                end
            end else if (expq.size() > 0) begin
                check("byte_hold", byte_out, expq[0]);
            end
        end
    end

    initial begin
        logic [19:0] vec;
        int          nvec;
        logic [7:0]  first_exp;
        int          lat;
        bit          seen;

        #3;
        check("init_byte_out", byte_out, 8'h00);
        check("init_byte_valid", byte_valid, 1'b0);
        check("init_health_fail", health_fail, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef ENTROPY_COLLECTOR_VON_NEUMANN_EN
        vec       = 20'b10_01_11_10_10_00_01_01_10_01;
        nvec      = 20;
        first_exp = 8'hB2;
`else
        vec       = 20'b1010_1010_0000_0000_0000;
        nvec      = 8;
        first_exp = 8'hAA;
`endif
        start_session();
        for (int i = 0; i < nvec; i++) send_sample(vec[19 - i]);
        lat  = nvec * 4;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (byte_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("first_byte_seen", seen, 1'b1);
        check("first_byte_value", byte_out, first_exp);
`ifndef ENTROPY_COLLECTOR_VON_NEUMANN_EN
        check("first_byte_latency_ok", (lat >= 32 && lat <= 36), 1'b1);
`endif
        stop_session();

        // Consumer stalled across two completions.
        byte_ready = 1'b0;
        start_session();
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        stop_session();
        check("stall_valid_held", byte_valid, 1'b1);
        byte_ready = 1'b1;
        slot_full  = 1'b0;
        @(posedge clk);
        #1;
        check("stall_valid_dropped", byte_valid, 1'b0);

        // Asynchronous reset mid-byte with a pending output.
        byte_ready = 1'b0;
        start_session();
        for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)));
        check("pending_before_reset", byte_valid, 1'b1);
        do_reset();
        byte_ready = 1'b1;
        slot_full  = 1'b0;
        start_session();
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        stop_session();

        // Enable dropped after a partial byte.
        start_session();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        stop_session();
        start_session();
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        stop_session();

        for (int s = 0; s < 3; s++) begin
            start_session();
            for (int i = 0; i < 48; i++) send_sample(1'($urandom_range(0, 1)));
            stop_session();
        end
        check("queue_drained", expq.size(), 0);

        // Stuck-at-1 source trips the repetition test on the 31st sample.
        start_session();
        for (int i = 0; i < 30; i++) send_sample(1'b1);
        check("health_before_trip", health_fail, 1'b0);
        send_sample(1'b1);
        @(posedge clk);
        #1;
        check("health_tripped", health_fail, 1'b1);
        check("fail_valid_low", byte_valid, 1'b0);
        ena = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            repeat (4) @(posedge clk);
            #1;
            check("health_sticky", health_fail, 1'b1);
            check("fail_valid_stays_low", byte_valid, 1'b0);
        end
        model_reset();
        do_reset();
        check("health_cleared", health_fail, 1'b0);
        check("queue_empty_end", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/entropy_collector.md
ENTROPY_COLLECTOR -- requirements
Module: entropy_collector

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 4, meaning clocks per raw-bit sample strobe (legal 1..255).
REQ-002 SHALL have parameter REP_LIMIT, default 31, meaning the consecutive-identical-sample count that trips the health test (legal 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  collection enable.
REQ-006 SHALL have port raw_bit  input  1  free-running ring-oscillator entropy bit, asynchronous to clk.
REQ-007 SHALL have port byte_out  output  8  conditioned random byte.
REQ-008 SHALL have port byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-009 SHALL have port byte_ready  input  1  consumer accepts byte.
REQ-010 SHALL have port health_fail  output  1  sticky repetition-test failure flag.

Function
REQ-011 SHALL pass raw_bit through a 2-flop synchronizer before any use; synchronizer latency 2 cycles.
REQ-012 SHALL run a sample counter 0..SAMPLE_DIV-1 only while ena=1; the strobe fires when counter = SAMPLE_DIV-1, then the counter wraps to 0.
REQ-013 SHALL, on each strobe, take the synchronized bit as one raw sample.
REQ-014 SHALL shift each accepted bit into an 8-bit shift register at the LSB, so the first accepted bit ends at byte_out[7]; a 3-bit count tracks bits 0..7.
REQ-015 SHALL, on the 8th accepted bit, load the output register with the completed byte, set byte_valid=1 and clear the bit count.
REQ-016 SHALL complete a transfer on a clock edge with byte_valid=1 and byte_ready=1; byte_valid then drops next cycle unless a new byte loads on the same edge.
REQ-017 SHALL hold byte_out stable while byte_valid=1 and byte_ready=0.
REQ-018 SHALL, when a byte completes while the output register is still valid and not being accepted, drop the new byte and continue collecting from bit 0.
REQ-019 SHALL, when completion and acceptance occur on the same edge, load the new byte and keep byte_valid=1.
REQ-020 SHALL run a repetition-count health test on every raw sample (pre-conditioning): increment the count on a sample equal to the previous one, else reset it to 1.
REQ-021 SHALL, when the repetition count reaches REP_LIMIT, set health_fail=1 and move the FSM to FAIL.
REQ-022 SHALL use FSM states COLLECT (ena=1, healthy), IDLE (ena=0) and FAIL; transitions IDLE<->COLLECT follow ena, and any state goes to FAIL on a trip.
REQ-023 SHALL make FAIL absorbing until rst_n: no sampling, byte_valid forced 0, pending byte discarded.
REQ-024 SHALL, on entering IDLE, clear the sample counter, shift register, bit count, pairing state and repetition count, while a pending valid byte remains until accepted.

Reset
REQ-025 SHALL, while rst_n=0, immediately force byte_out=0x00, byte_valid=0, health_fail=0, the FSM to IDLE, and clear all counters and synchronizer flops.
REQ-026 SHALL, after rst_n release, restart collection at bit 0 on the first strobe after ena=1.

Configuration
REQ-027 SHALL apply von Neumann debiasing when macro ENTROPY_COLLECTOR_VON_NEUMANN_EN is defined: raw samples are paired; a differing pair (a,b) yields accepted bit a; an equal pair yields nothing.
REQ-028 SHALL, when ENTROPY_COLLECTOR_VON_NEUMANN_EN is undefined, accept every raw sample directly and contain no pairing logic.

Verification
REQ-029 SHALL cover: no-VN build, SAMPLE_DIV=4, ena=1, samples alternating from 1 -> byte_valid after 8 strobes (~34 clocks) with byte_out=0xAA.
REQ-030 SHALL cover: VN build, sample pairs 10,01,11,10,10,00,01,01,10,01 -> accepted bits 10110010 -> byte_out=0xB2; equal pairs produce no bit.
REQ-031 SHALL cover: byte_ready=0 across two byte completions -> first byte stays on byte_out unchanged and the second is dropped; after byte_ready=1 for one edge, byte_valid=0.
REQ-032 SHALL cover: raw_bit held 1, REP_LIMIT=31 -> health_fail=1 on the 31st strobe and byte_valid=0 thereafter; toggling ena does not clear it, only rst_n does.
REQ-033 SHALL cover: rst_n pulsed low after 5 accepted bits -> all outputs 0 without waiting for clk; the next byte is formed from 8 fresh bits.
REQ-034 SHALL cover: ena dropped after 3 bits, then raised -> partial bits discarded; the next byte equals the following 8 samples.
